// File: rtl/average_divide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : average_divide_sequencer
// Description : Turns per-pixel accumulated sums into an 8-bit average
//               template using one shared serial restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module average_divide_sequencer #(
  parameter int NUM_PIXELS = 784,
  parameter int SUM_W      = 24,
  parameter int CNT_W      = 14,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_images,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_div_zero,
  output logic              o_sum_rd_en,
  output logic [ADDR_W-1:0] o_sum_addr,
  input  logic [SUM_W-1:0]  i_sum_rd_data,
  output logic              o_avg_wr_en,
  output logic [ADDR_W-1:0] o_avg_wr_addr,
  output logic [PIX_W-1:0]  o_avg_wr_data
);

  localparam int                C_BIT_W    = $clog2(SUM_W);
  localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(SUM_W - 1);
  localparam logic [ADDR_W-1:0]  C_LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_DIV   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_div;
  logic [ADDR_W-1:0]    r_pix;
  logic [CNT_W:0]       r_rem;
  logic [SUM_W-1:0]     r_quo;
  logic [C_BIT_W-1:0]   r_bit;
  logic                 r_err;
  logic [ADDR_W-1:0]    r_sum_addr;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [PIX_W-1:0]     r_wr_data;

  logic [CNT_W+1:0]     w_rem_sh;
  logic [CNT_W+1:0]     w_diff;
  logic                 w_ge;
  logic [SUM_W-1:0]     w_quo_next;
  logic [PIX_W-1:0]     w_quo_sat;

  // Remainder stays below the divisor, so the shifted value never exceeds
  // 2^(CNT_W+1); the top bit of the difference is therefore a valid sign.
  assign w_rem_sh   = {r_rem, r_quo[SUM_W-1]};
  assign w_diff     = w_rem_sh - {2'b00, r_div};
  assign w_ge       = ~w_diff[CNT_W+1];
  assign w_quo_next = {r_quo[SUM_W-2:0], w_ge};
  assign w_quo_sat  = (|w_quo_next[SUM_W-1:PIX_W]) ? {PIX_W{1'b1}} : w_quo_next[PIX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_num_images == '0) ? S_DONE : S_READ;
      S_READ:  w_next = S_LOAD;
      S_LOAD:  w_next = S_DIV;
      S_DIV:   if (r_bit == C_LAST_BIT) w_next = S_WRITE;
      S_WRITE: w_next = (r_pix == C_LAST_PIX) ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_pix      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_bit      <= '0;
      r_err      <= 1'b0;
      r_sum_addr <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_div <= i_num_images;
            r_pix <= '0;
            r_err <= (i_num_images == '0);
            if (i_num_images != '0) r_sum_addr <= '0;
          end
        end
        S_LOAD: begin
          r_quo <= i_sum_rd_data;
          r_rem <= '0;
          r_bit <= '0;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff[CNT_W:0] : w_rem_sh[CNT_W:0];
          r_quo <= w_quo_next;
          r_bit <= r_bit + C_BIT_W'(1);
          if (r_bit == C_LAST_BIT) begin
            r_wr_addr <= r_pix;
            r_wr_data <= w_quo_sat;
          end
        end
        S_WRITE: begin
          if (r_pix != C_LAST_PIX) begin
            r_pix      <= r_pix + ADDR_W'(1);
            r_sum_addr <= r_pix + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_err_div_zero = r_err;
  assign o_sum_rd_en    = (r_state == S_READ);
  assign o_sum_addr     = r_sum_addr;
  assign o_avg_wr_en    = (r_state == S_WRITE);
  assign o_avg_wr_addr  = r_wr_addr;
  assign o_avg_wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_average_divide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_average_divide_sequencer
// Description : Self-checking bench for average_divide_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_average_divide_sequencer;

  localparam int NPIX = 784;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [13:0] i_num_images;
  logic        o_busy, o_done, o_err_div_zero, o_sum_rd_en, o_avg_wr_en;
  logic [9:0]  o_sum_addr, o_avg_wr_addr;
  logic [23:0] i_sum_rd_data;
  logic [7:0]  o_avg_wr_data;

  average_divide_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_num_images  (i_num_images),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_div_zero(o_err_div_zero),
    .o_sum_rd_en   (o_sum_rd_en),
    .o_sum_addr    (o_sum_addr),
    .i_sum_rd_data (i_sum_rd_data),
    .o_avg_wr_en   (o_avg_wr_en),
    .o_avg_wr_addr (o_avg_wr_addr),
    .o_avg_wr_data (o_avg_wr_data)
  );

  always #5 clk = ~clk;

  // Sum memory: synchronous read, data one cycle after the strobe.
  logic [23:0] mem [NPIX];
  initial i_sum_rd_data = '0;
  always @(posedge clk) if (o_sum_rd_en) i_sum_rd_data <= mem[o_sum_addr];

  int npass = 0;
  int ntotal = 0;

  logic [9:0] wa[$];
  logic [7:0] wd[$];
  logic [9:0] ra[$];
  int   done_n, done_rel, first_wr_rel, last_wr_rel, first_rd_rel;
  logic busy_after, err_after, err_at_done, err_c1, busy_c1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_avg(input logic [23:0] s, input logic [13:0] d);
    int unsigned q;
    q = int'(s) / int'(d);
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  // One pass: start at cycle 0, observe every cycle at the falling edge.
  task automatic run_pass(input logic [13:0] div, input bit pulses, input int abort_at);
    int rel;
    bit fin;
    wa.delete(); wd.delete(); ra.delete();
    done_n = 0; done_rel = -1; first_wr_rel = -1; last_wr_rel = -1; first_rd_rel = -1;
    busy_after = 1'bx; err_after = 1'bx; err_at_done = 1'bx; err_c1 = 1'bx; busy_c1 = 1'bx;
    @(negedge clk);
    i_start = 1'b1;
    i_num_images = div;
    rel = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      rel++;
      if (rel == 1) begin err_c1 = o_err_div_zero; busy_c1 = o_busy; end
      if (o_sum_rd_en) begin
        if (first_rd_rel < 0) first_rd_rel = rel;
        ra.push_back(o_sum_addr);
      end
      if (o_avg_wr_en) begin
        if (first_wr_rel < 0) first_wr_rel = rel;
        last_wr_rel = rel;
        wa.push_back(o_avg_wr_addr);
        wd.push_back(o_avg_wr_data);
      end
      if (o_done) begin done_n++; done_rel = rel; err_at_done = o_err_div_zero; end
      if (done_rel > 0 && rel == done_rel + 1) begin
        busy_after = o_busy; err_after = o_err_div_zero; fin = 1;
      end
      i_start = pulses && (rel == 5 || rel == 10000);
      if (pulses && rel == 300) i_num_images = 14'd7;
      if (abort_at != 0 && rel == abort_at) begin rst_n = 1'b0; fin = 1; end
      if (rel >= 22000) fin = 1;
    end
    i_start = 1'b0;
  endtask

  task automatic check_data(input string tag, input logic [13:0] div, input int n);
    chk({tag, " write count"}, wd.size(), n);
    chk({tag, " read count"}, ra.size(), n);
    for (int i = 0; i < wd.size() && i < n; i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), wa[i], i);
      chk($sformatf("%s wr_data[%0d]", tag, i), wd[i], ref_avg(mem[i], div));
    end
    for (int i = 0; i < ra.size() && i < n; i++)
      chk($sformatf("%s rd_addr[%0d]", tag, i), ra[i], i);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_num_images = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {o_busy, o_done, o_err_div_zero, o_sum_rd_en, o_avg_wr_en,
                          o_sum_addr, o_avg_wr_addr, o_avg_wr_data}, 64'd0);
    rst_n = 1'b1;

    // Identity divisor with timing checks
    for (int i = 0; i < NPIX; i++) mem[i] = 24'(i % 256);
    run_pass(14'd1, 1'b0, 0);
    check_data("identity", 14'd1, NPIX);
    chk("identity busy c1", busy_c1, 1'b1);
    chk("identity first read cycle", first_rd_rel, 1);
    chk("identity first write cycle", first_wr_rel, 27);
    chk("identity last write cycle", last_wr_rel, 21168);
    chk("identity done cycle", done_rel, 21169);
    chk("identity done count", done_n, 1);
    chk("identity err", err_at_done, 1'b0);
    chk("identity busy after done", busy_after, 1'b0);

    // Divide-by-zero
    run_pass(14'd0, 1'b0, 0);
    chk("divzero done cycle", done_rel, 1);
    chk("divzero err with done", err_at_done, 1'b1);
    chk("divzero busy c2", busy_after, 1'b0);
    chk("divzero err holds", err_after, 1'b1);
    chk("divzero reads", ra.size(), 0);
    chk("divzero writes", wd.size(), 0);

    // Truncation; error flag cleared at the accept edge
    for (int i = 0; i < NPIX; i++) mem[i] = 24'(100 + i);
    run_pass(14'd3, 1'b0, 0);
    chk("trunc err cleared c1", err_c1, 1'b0);
    chk("trunc pixel0", wd.size() > 0 ? wd[0] : 8'hxx, 8'd33);
    chk("trunc pixel2", wd.size() > 2 ? wd[2] : 8'hxx, 8'd34);
    check_data("trunc", 14'd3, NPIX);
    chk("trunc done count", done_n, 1);

    // Start while busy and divisor change mid-pass
    for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom_range(0, 2000));
    run_pass(14'd4, 1'b1, 0);
    check_data("busy-start", 14'd4, NPIX);
    chk("busy-start done count", done_n, 1);
    chk("busy-start done cycle", done_rel, 21169);

    // Maximum count, aborted by reset during pixel 10's division
    mem[0] = 24'hFFFFFF;
    mem[1] = 24'(16383 * 200);
    for (int i = 2; i < NPIX; i++) mem[i] = 24'($urandom);
    run_pass(14'd16383, 1'b0, 280);
    #1;
    chk("abort reset outputs", {o_busy, o_done, o_err_div_zero, o_sum_rd_en, o_avg_wr_en,
                                o_sum_addr, o_avg_wr_addr, o_avg_wr_data}, 64'd0);
    chk("maxcnt pixel0", wd.size() > 0 ? wd[0] : 8'hxx, 8'd255);
    chk("maxcnt pixel1", wd.size() > 1 ? wd[1] : 8'hxx, 8'd200);
    chk("abort writes before reset", wd.size(), 10);
    for (int i = 0; i < wd.size() && i < 10; i++)
      chk($sformatf("maxcnt wr_data[%0d]", i), wd[i], ref_avg(mem[i], 14'd16383));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_avg_wr_en || o_sum_rd_en || o_busy) cnt++;
    end
    chk("activity after reset release", cnt, 0);

    // Fresh pass after reset: saturation with divisor 1
    mem[0] = 24'hFFFFFF;
    for (int i = 1; i < NPIX; i++) mem[i] = 24'($urandom_range(0, 511));
    run_pass(14'd1, 1'b0, 0);
    chk("sat pixel0", wd.size() > 0 ? wd[0] : 8'hxx, 8'd255);
    check_data("post-reset", 14'd1, NPIX);
    chk("post-reset done cycle", done_rel, 21169);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/average_divide_sequencer.md
# average_divide_sequencer

Sequential controller that turns the per-pixel accumulated image sums into the 8-bit class-average template. It reads each 24-bit sum from the sum memory one pixel at a time and divides it by the image count with a shared serial restoring divider. It writes the saturated 8-bit quotient to the template memory. It replaces 784 parallel combinational dividers with one divider sequenced over NUM_PIXELS × 27 cycles, and sits between the accumulation stage and the classifier's template store.

## Interface
Parameters:
- NUM_PIXELS, 784, pixels per image
- SUM_W, 24, width of one accumulated pixel sum
- CNT_W, 14, width of the image count
- PIX_W, 8, width of one averaged output pixel
- ADDR_W, 10, pixel address width (≥ clog2(NUM_PIXELS))

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  request a full averaging pass; sampled only in IDLE
- num_images  in  CNT_W  divisor; latched on the start-accept edge
- busy  out  1  high from the start-accept edge until DONE is left
- done  out  1  one-cycle pulse at pass completion
- err_div_zero  out  1  high with done when the latched divisor was 0; holds until the next accepted start
- sum_rd_en  out  1  read strobe to the sum memory
- sum_addr  out  ADDR_W  pixel index being read
- sum_rd_data  in  SUM_W  sum memory data, valid exactly one cycle after sum_rd_en
- avg_wr_en  out  1  write strobe to the template memory
- avg_wr_addr  out  ADDR_W  pixel index being written
- avg_wr_data  out  PIX_W  averaged pixel value

## Operation
- States: IDLE, READ, LOAD, DIV, WRITE, DONE.
- **IDLE**
  - If start is 1: latch num_images into div_reg, clear the pixel index and err_div_zero.
  - If num_images == 0: set err_div_zero and go to DONE.
  - Otherwise go to READ.
- **READ**: assert sum_rd_en for one cycle with sum_addr = pixel index, then go to LOAD.
- **LOAD**: capture sum_rd_data into the dividend/quotient shift register, clear the remainder (CNT_W+1 bits) and the bit counter, then go to DIV.
- **DIV**: one restoring-division step per cycle, SUM_W cycles in total.
  - Each step: shift {rem, quo} left by 1 and form trial = rem − div_reg.
  - If trial is non-negative: rem = trial and the quotient LSB = 1.
  - After the step with bit counter = SUM_W−1, go to WRITE.
- **WRITE**
  - Assert avg_wr_en with avg_wr_addr = pixel index and avg_wr_data = min(quotient, 2^PIX_W − 1). Quotients of 256 or more write 255; division truncates toward zero.
  - If pixel index == NUM_PIXELS−1, go to DONE. Otherwise increment the index and go to READ.
- **DONE**: done = 1 for one cycle, then go to IDLE.
- start is ignored in every state other than IDLE. No queuing, and num_images changes while busy have no effect.
- Divide-by-zero pass: no sum_rd_en and no avg_wr_en are issued.

## Timing
- Reset (asynchronous, reset = 0) forces:
  - state to IDLE
  - busy, done, err_div_zero, sum_rd_en, avg_wr_en to 0
  - sum_addr, avg_wr_addr, avg_wr_data to 0
  - internal registers cleared
- Reset mid-pass aborts immediately: no further writes, and the template memory holds a partial result.
- All outputs are registered or decoded from the registered state only. No combinational path from inputs to outputs.
- Let E0 be the start-accept edge. Cycles are counted after E0:
  - Pixel p's READ falls on cycle 27p+1, its LOAD on 27p+2, its DIV on 27p+3 to 27p+26, and its WRITE on 27p+27.
  - The last WRITE is on cycle 21168, done is high on cycle 21169, and the block is back in IDLE (busy = 0) on cycle 21170.
- Divide-by-zero pass: done and err_div_zero are high on cycle 1, and busy is 0 from cycle 2.
- A start held high continuously launches a new pass on the first IDLE cycle after DONE.
- sum_addr holds its value outside READ; avg_wr_* hold their values outside WRITE. Consumers qualify on the strobes.

## Test plan
- **Identity divisor**
  - Stimulus: num_images = 1, sum[p] = p mod 256.
  - Required: 784 writes with avg_wr_data[p] = p mod 256, done on cycle 21169, err_div_zero = 0.
- **Truncation**
  - Stimulus: num_images = 3, sum[p] = 100 + p, start.
  - Required: each write equals floor((100+p)/3). Pixel 0 writes 33 and pixel 2 writes 34.
- **Saturation and maximum count**
  - Stimulus: sum[0] = 0xFFFFFF with num_images = 1.
  - Required: pixel 0 writes 255.
  - Stimulus: num_images = 16383 with sum = 0xFFFFFF.
  - Required: 255 is written (the quotient of 1024 saturates). sum = 16383 × 200 writes 200.
- **Divide-by-zero**
  - Stimulus: num_images = 0, start.
  - Required: done and err_div_zero high on cycle 1, no sum_rd_en or avg_wr_en ever.
  - Stimulus: next start with num_images = 2.
  - Required: err_div_zero cleared at the accept edge.
- **Start while busy / divisor change**
  - Stimulus: start pulses at cycles 5 and 10000, num_images changed from 4 to 7 mid-pass.
  - Required: a single pass, all quotients computed with 4, exactly one done pulse.
- **Reset mid-pass**
  - Stimulus: assert reset during pixel 10's DIV state.
  - Required: all outputs are 0 immediately (asynchronous) and there are no writes after release.
  - Stimulus: a new start after release.
  - Required: a full, correct pass beginning at pixel 0.
